// File: rtl/truth_sweep_pkg.sv
// Shared types and helpers for the truth-table sweeper: sequencer states,
// vector geometry and the lowest-mismatch priority encoder.
package truth_sweep_pkg;

    localparam int N_VEC = 8;
    localparam int VEC_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } sweep_state_t;

    // Scanning from the top down lets the lowest set bit overwrite, so bit 0 wins.
    function automatic logic [VEC_W-1:0] lowest_set(input logic [N_VEC-1:0] v);
        logic [VEC_W-1:0] idx_v;
        idx_v = {VEC_W{1'b0}};
        for (int i = N_VEC - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx_v = VEC_W'(i);
            end
        end
        return idx_v;
    endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// Loadable down-counter that times how long each vector is held; expire is
// high for the single cycle in which the count has run out while running.
module sweep_settle_timer #(
    parameter int unsigned SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic run,
    output logic expire
);

    localparam int unsigned CNT_W = $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE - 1);

    logic [CNT_W-1:0] cnt_r;

    // Reload at the start of each vector window, then count down to zero and stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= ZERO;
        end else if (load) begin
            cnt_r <= RELOAD;
        end else if (run && (cnt_r != ZERO)) begin
            cnt_r <= cnt_r - ONE;
        end
    end

    assign expire = run & (cnt_r == ZERO);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives all eight A/B/C vectors into a function under test, captures Y for
// each after a settle time and compares the captured table with an expected one.
module truth_table_sweeper
    import truth_sweep_pkg::*;
#(
    parameter int unsigned SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N_VEC-1:0] expected,
    input  logic             y_in,
    output logic [VEC_W-1:0] abc_out,
    output logic             busy,
    output logic             done,
    output logic [N_VEC-1:0] captured,
    output logic             pass,
    output logic [VEC_W-1:0] fail_idx
);

    localparam logic [VEC_W-1:0] LAST_IDX = VEC_W'(N_VEC - 1);

    sweep_state_t     state_r;
    sweep_state_t     next_state_s;
    logic [VEC_W-1:0] idx_r;
    logic [N_VEC-1:0] captured_r;
    logic [N_VEC-1:0] captured_nxt_s;
    logic [N_VEC-1:0] mismatch_s;
    logic             busy_r;
    logic             done_r;
    logic             pass_r;
    logic [VEC_W-1:0] fail_idx_r;
    logic             start_sweep_s;
    logic             sample_s;
    logic             last_s;
    logic             run_s;
    logic             expire_s;

    assign run_s = (state_r == DRIVE);

    sweep_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (start_sweep_s | (sample_s & ~last_s)),
        .run    (run_s),
        .expire (expire_s)
    );

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode plus the per-cycle strobes that steer the datapath.
    always_comb begin
        next_state_s  = state_r;
        start_sweep_s = 1'b0;
        sample_s      = 1'b0;
        last_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s  = DRIVE;
                    start_sweep_s = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            DRIVE: begin
                if (expire_s) begin
                    sample_s = 1'b1;
                    if (idx_r == LAST_IDX) begin
                        last_s       = 1'b1;
                        next_state_s = DONE;
                    end else begin
                        next_state_s = DRIVE;
                    end
                end else begin
                    next_state_s = DRIVE;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // The verdict must see the final sample, so compare against the table with this cycle's Y merged in.
    always_comb begin
        captured_nxt_s        = captured_r;
        captured_nxt_s[idx_r] = y_in;
        mismatch_s            = captured_nxt_s ^ expected;
    end

    // Vector index, capture register, status flags and verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r      <= {VEC_W{1'b0}};
            captured_r <= {N_VEC{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
            fail_idx_r <= {VEC_W{1'b0}};
        end else begin
            done_r <= 1'b0;
            if (start_sweep_s) begin
                idx_r      <= {VEC_W{1'b0}};
                captured_r <= {N_VEC{1'b0}};
                busy_r     <= 1'b1;
                pass_r     <= 1'b0;
                fail_idx_r <= {VEC_W{1'b0}};
            end else if (sample_s) begin
                captured_r <= captured_nxt_s;
                if (last_s) begin
                    idx_r      <= {VEC_W{1'b0}};
                    busy_r     <= 1'b0;
                    done_r     <= 1'b1;
                    pass_r     <= (mismatch_s == {N_VEC{1'b0}});
                    fail_idx_r <= lowest_set(mismatch_s);
                end else begin
                    idx_r <= idx_r + VEC_W'(1);
                end
            end
        end
    end

    assign abc_out  = idx_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign captured = captured_r;
    assign pass     = pass_r;
    assign fail_idx = fail_idx_r;

endmodule
